proc_control_fsm: RTL

- Multi-cycle control unit for the 16-bit processor datapath.
- Latches an instruction word from DIN and sequences the bus multiplexer selects, register/accumulator load enables and ALU operation.
- Sits directly upstream of the bus mux tree (including the 1-bit MUX6 slices) and drives every select/enable line it consumes.

---
 rtl/proc_pkg.sv | 37 +++
 rtl/reg_dec3to8.sv | 15 +
 rtl/proc_control_fsm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor control unit: opcodes, bus selects,
// ALU function codes and the sequencer state encoding.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_IDLE = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // ALU opcodes are laid out contiguously starting at OP_ADD.
    function automatic logic [2:0] alu_of(input logic [2:0] op);
        return op - OP_ADD;
    endfunction

endpackage

// File: rtl/reg_dec3to8.sv
// 3-bit register index to one-hot load enable; all zeros when not enabled.
module reg_dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: captures an instruction from DIN and sequences bus
// selects, register/accumulator loads and the ALU function over T1..T3.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for Run; captures DIN into IR when Run=1
//   S_T1   | mv/mvi write Rx; ALU ops load A from Rx; illegal ends here
//   S_T2   | ALU ops: Ry on bus, G <= A op bus
//   S_T3   | ALU ops: G on bus, write Rx
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter logic [3:0] BUS_IDLE = 4'hF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [3:0]        bus_sel,
    output logic [7:0]        r_in,
    output logic              a_in,
    output logic              g_in,
    output logic [2:0]        alu_op,
    output logic              ir_load,
    output logic              done,
    output logic              illegal
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [2:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic              wr_en;
    logic              unused_ir_low;

    assign op            = ir[DATA_W-1 -: 3];
    assign rx            = ir[DATA_W-4 -: 3];
    assign ry            = ir[DATA_W-7 -: 3];
    assign unused_ir_low = ^ir[DATA_W-10:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        ir    <= DIN;
                        state <= S_T1;
                    end
                end
                S_T1:    state <= is_alu_op(op) ? S_T2 : S_IDLE;
                S_T2:    state <= S_T3;
                S_T3:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state/IR so a mid-cycle Reset drops them at once.
    always_comb begin
        bus_sel = BUS_IDLE;
        wr_en   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = ALU_ADD;
        ir_load = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state)
            S_IDLE: begin
                ir_load = Run & ~Reset;
            end
            S_T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = {1'b0, ry};
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus_sel = {1'b0, rx};
                        a_in    = 1'b1;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                bus_sel = {1'b0, ry};
                g_in    = 1'b1;
                alu_op  = alu_of(op);
            end
            S_T3: begin
                bus_sel = SEL_G;
                wr_en   = 1'b1;
                done    = 1'b1;
            end
            default: begin
                bus_sel = BUS_IDLE;
            end
        endcase
    end

    reg_dec3to8 u_rdec (
        .sel    (rx),
        .en     (wr_en),
        .onehot (r_in)
    );

endmodule
